udm_host: RTL and testbench
===========================

# udm_host

Host-side initiator for the UART debug-master (UDM) link on the sigma SoC, i.e. the far end of the `rx_i`/`tx_o` pair. A simple word-access request port is serialized into UDM write/read frames on `tx_o`. Read-response bytes are collected from `rx_i` and returned on the request port. It is used in self-test benches and board-to-board loaders, where one FPGA drives a sigma instance's UART without a PC.

## Interface
- `BAUD_DIV`, 868 — clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- `TIMEOUT_CYC`, 2000000 — maximum idle cycles allowed between read-response bytes before the read is abandoned.
- `clk_i`  in  1  — single clock domain.
- `rst_i`  in  1  — reset; **synchronous, active-high**.
- `req_i`  in  1  — access request; held with its fields until `ack_o`.
- `we_i`  in  1  — 1 selects a write, 0 selects a read.
- `addr_i`  in  32  — word address, byte-addressed; bits [1:0] are ignored and sent as 0.
- `wdata_i`  in  32  — write data.
- `ack_o`  out  1  — one-cycle pulse; the request fields are captured on this cycle.
- `resp_o`  out  1  — one-cycle pulse when the access completes, whether OK or timed out.
- `rdata_o`  out  32  — read data; valid on `resp_o` for reads and held until the next `resp_o`.
- `timeout_o`  out  1  — valid with `resp_o`; 1 means the read got no complete response.
- `busy_o`  out  1  — high from `ack_o` through the `resp_o` cycle inclusive.
- `tx_o`  out  1  — UART transmit line toward the target `rx_i`.
- `rx_i`  in  1  — UART receive line from the target `tx_o`; asynchronous.

## Operation
- **UART format:** 8N1, LSB first, idle high. One bit lasts exactly `BAUD_DIV` cycles.
- **Frame layout:** bytes go out back-to-back with no idle gap:
  - `0x55` sync.
  - Command byte: `0x81` for a write, `0x82` for a read.
  - Address, 4 bytes, little-endian.
  - Length, 4 bytes, little-endian, always `0x00000004`.
  - Write only: data, 4 bytes, little-endian.
- **Frame length:** a write frame is 14 bytes; a read frame is 10 bytes.
- **Response:** the target returns exactly 4 bytes, little-endian, for a read. A write gets no response.
- **FSM states:** IDLE, SEND, WAIT_RX, DONE.
  - IDLE: on `req_i`, pulse `ack_o`, latch `we`/`addr`/`wdata`, go to SEND.
  - SEND: a byte counter indexes the frame, and the bit-level transmitter shifts out each byte. After the stop bit of the last byte:
    - write → DONE;
    - read → WAIT_RX, clearing the byte count and the timeout counter.
  - WAIT_RX: each valid received byte is placed at `rdata[8k+7:8k]` and resets the timeout counter. On the 4th byte → DONE with `timeout_o=0`. If the timeout counter reaches `TIMEOUT_CYC` → DONE with `timeout_o=1`; `rdata_o` then holds the bytes received so far, with the rest 0.
  - DONE: pulse `resp_o` for one cycle, then return to IDLE.
- **Receiver path:**
  - `rx_i` passes through a 2-FF synchronizer.
  - Start is detected on a falling edge while the receiver is idle.
  - The start bit is re-checked at `BAUD_DIV/2` (integer divide); if it reads high, the start is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every `BAUD_DIV` cycles after that point.
  - A stop bit sampled as 0 is a framing error: the byte is discarded and the receiver waits for the line to go high before hunting again.
- **Receiver enable:** the receiver runs in every state. Bytes arriving outside WAIT_RX are dropped.
- **Request handling:** `req_i` is ignored while `busy_o`=1; there is no queueing.

## Timing
- **Reset values:** `tx_o`=1; `ack_o`, `resp_o`, `timeout_o`, `busy_o`=0; `rdata_o`=0; FSM in IDLE; all counters 0.
- **Reset mid-frame:** `tx_o` returns to 1 on the next cycle. The target must resynchronize on its next `0x55`.
- **`ack_o`:** asserted in the cycle after `req_i` is first sampled high in IDLE.
- **Start bit:** `tx_o` falls on the cycle after `ack_o`.
- **Write latency:** `resp_o` is asserted exactly 14·10·`BAUD_DIV` cycles after the start bit begins, +1.
- **Read latency:** the read frame occupies 100·`BAUD_DIV` cycles. `resp_o` follows the cycle in which the 4th byte's stop-bit sample is taken, +1.
- **Back-to-back requests:** `req_i` may already be high during the `resp_o` cycle; the next `ack_o` follows 1 cycle later (in IDLE).
- **Counter widths:** the bit-timer is 16 bits and the timeout counter is 32 bits. Neither may wrap: each is cleared at every reload.

## Test plan
- **Write frame:** `BAUD_DIV`=4, write `addr`=0x00001004, `wdata`=0xDEADBEEF → a UART monitor decodes 55 81 04 10 00 00 04 00 00 00 EF BE AD DE. `resp_o` arrives at 561 cycles, `timeout_o`=0.
- **Read frame and response:** read `addr`=0x80000000; the model replies 78 56 34 12 → frame 55 82 00 00 00 80 04 00 00 00; `rdata_o`=0x12345678, `timeout_o`=0.
- **Timeout:** read with `TIMEOUT_CYC`=200; the model replies only AA BB → `resp_o` with `timeout_o`=1 and `rdata_o`=0x0000BBAA.
- **Receiver robustness:**
  - a 1-cycle low glitch on `rx_i` is ignored;
  - a byte with its stop bit forced to 0 is discarded, and the following valid byte is still captured;
  - response bytes sent during SEND are dropped.
- **Reset mid-frame:** `rst_i` pulsed during the 5th byte → `tx_o`=1 on the next cycle and `busy_o`=0; a new write then completes normally.
- **Back-to-back requests:** `req_i` held high for two requests → the second `ack_o` follows the first `resp_o` by 1 cycle, and `req_i` is ignored while busy.

Source files
------------

// File: rtl/udm_host_if.sv
// Word-access request port between a requester and udm_host.
interface udm_host_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic        resp_o;
  logic [31:0] rdata_o;
  logic        timeout_o;
  logic        busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, resp_o, rdata_o, timeout_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, resp_o, rdata_o, timeout_o, busy_o
  );
endinterface

// File: rtl/udm_host.sv
// Host-side UDM initiator: serializes word writes/reads into UART frames on tx_o
// and gathers the 4-byte read response from rx_i.
module udm_host #(
  parameter int unsigned BAUD_DIV    = 868,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  udm_host_if.slave bus,
  output logic      tx_o,
  input  logic      rx_i
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT_RX = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd3;
  localparam logic [2:0] R_HUNT  = 3'd4;

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ack_q;
  logic        resp_q;
  logic        busy_q;
  logic        timeout_q;
  logic        to_flag;
  logic [31:0] rdata_q;
  logic [31:0] rbuf;
  logic [1:0]  rx_num;
  logic [31:0] to_cnt;

  logic        tx_run;
  logic [3:0]  tx_idx;
  logic [3:0]  tx_bit;
  logic [15:0] tx_cnt;
  logic [7:0]  cur_byte;
  logic [3:0]  last_idx;

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [2:0]  rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_stb;

  assign bus.ack_o     = ack_q;
  assign bus.resp_o    = resp_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;
  assign bus.rdata_o   = rdata_q;

  assign last_idx = we_q ? 4'd13 : 4'd9;

  always_comb begin
    cur_byte = '0;
    case (tx_idx)
      4'd0:    cur_byte = 8'h55;
      4'd1:    cur_byte = we_q ? 8'h81 : 8'h82;
      4'd2:    cur_byte = addr_q[7:0];
      4'd3:    cur_byte = addr_q[15:8];
      4'd4:    cur_byte = addr_q[23:16];
      4'd5:    cur_byte = addr_q[31:24];
      4'd6:    cur_byte = 8'h04;
      4'd10:   cur_byte = wdata_q[7:0];
      4'd11:   cur_byte = wdata_q[15:8];
      4'd12:   cur_byte = wdata_q[23:16];
      4'd13:   cur_byte = wdata_q[31:24];
      default: cur_byte = '0;
    endcase
  end

  // A byte is only complete once its stop bit samples high.
  assign rx_stb = (rx_st == R_STOP) && (rx_cnt == BIT_LAST) && rx_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_st)
        R_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt <= '0;
            rx_st  <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_st  <= rx_sync ? R_IDLE : R_HUNT;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        R_HUNT: begin
          if (rx_sync) rx_st <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      resp_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      to_flag   <= 1'b0;
      rdata_q   <= '0;
      rbuf      <= '0;
      rx_num    <= '0;
      to_cnt    <= '0;
      tx_run    <= 1'b0;
      tx_idx    <= '0;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      tx_o      <= 1'b1;
    end else begin
      ack_q  <= 1'b0;
      resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (resp_q) busy_q <= 1'b0;
          if (bus.req_i) begin
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i & 32'hFFFF_FFFC;
            wdata_q <= bus.wdata_i;
            to_flag <= 1'b0;
            tx_idx  <= '0;
            tx_run  <= 1'b0;
            state   <= SEND;
          end
        end
        SEND: begin
          // First SEND cycle is the ack cycle; the start bit begins one cycle later.
          if (!tx_run) begin
            tx_run <= 1'b1;
            tx_o   <= 1'b0;
            tx_bit <= '0;
            tx_cnt <= '0;
          end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              if (tx_idx == last_idx) begin
                tx_run <= 1'b0;
                if (we_q) begin
                  state <= DONE;
                end else begin
                  rx_num <= '0;
                  to_cnt <= '0;
                  rbuf   <= '0;
                  state  <= WAIT_RX;
                end
              end else begin
                tx_idx <= tx_idx + 4'd1;
                tx_bit <= '0;
                tx_o   <= 1'b0;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              tx_o   <= (tx_bit == 4'd8) ? 1'b1 : cur_byte[tx_bit[2:0]];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        WAIT_RX: begin
          if (rx_stb) begin
            rbuf[{rx_num, 3'b000} +: 8] <= rx_shift;
            to_cnt <= '0;
            rx_num <= rx_num + 2'd1;
            if (rx_num == 2'd3) begin
              to_flag <= 1'b0;
              state   <= DONE;
            end
          end else if (to_cnt == TO_LAST) begin
            to_cnt  <= '0;
            to_flag <= 1'b1;
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        DONE: begin
          resp_q    <= 1'b1;
          timeout_q <= to_flag;
          if (!we_q) rdata_q <= rbuf;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udm_host.sv
// Scoreboard bench for udm_host: decodes tx_o, plays the target on rx_i,
// and checks each response against a byte-level reference model.
module tb_udm_host;
  localparam int unsigned B  = 4;
  localparam int unsigned TO = 200;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          to;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  udm_host_if bus ();

  udm_host #(.BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .tx_o  (tx),
    .rx_i  (rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_tx[$];
  resp_t      exp_resp[$];
  int  tx_count = 0, resp_count = 0, ack_count = 0;
  int  last_resp_cyc = 0;
  bit  tx_ignore = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // UART decoder on tx_o
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = tx;
        end
        repeat (B) @(negedge clk);
        if (!tx_ignore) begin
          check("tx_stop", 32'(tx), 32'd1);
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_extra: got %h expected no byte", b);
          end else begin
            check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
          end
        end
        tx_count++;
      end
    end
  end

  resp_t mon_r;
  always @(negedge clk) begin
    if (bus.ack_o) ack_count++;
    if (bus.resp_o) begin
      resp_count++;
      last_resp_cyc = cyc;
      check("busy_at_resp", 32'(bus.busy_o), 32'd1);
      if (exp_resp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_extra: got resp expected none");
      end else begin
        mon_r = exp_resp.pop_front();
        check("timeout", 32'(bus.timeout_o), 32'(mon_r.to));
        if (mon_r.rd) check("rdata", bus.rdata_o, mon_r.data);
      end
    end
  end

  task automatic push_frame(input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] aa;
    aa = a & ~32'h3;
    exp_tx.push_back(8'h55);
    exp_tx.push_back(we ? 8'h81 : 8'h82);
    for (int i = 0; i < 4; i++) exp_tx.push_back(aa[8*i +: 8]);
    exp_tx.push_back(8'h04);
    for (int i = 0; i < 3; i++) exp_tx.push_back(8'h00);
    if (we) for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d);
    int t;
    @(negedge clk);
    bus.we_i    = we;
    bus.addr_i  = a;
    bus.wdata_i = d;
    bus.req_i   = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.ack_o && t < 100);
    if (!bus.ack_o) fail_now("ack_wait");
    bus.req_i = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int t = 0;
    while (tx_count < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (tx_count < target) fail_now("tx_wait");
  endtask

  task automatic wait_resp(input int target);
    int t = 0;
    while (resp_count < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (resp_count < target) fail_now("resp_wait");
  endtask

  task automatic send_rx(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (bad_stop ? 3 * B : 2) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int base, rc;
    base = tx_count;
    rc   = resp_count;
    push_frame(1'b1, a, d);
    exp_resp.push_back('{rd: 1'b0, data: 32'h0, to: 1'b0});
    issue(1'b1, a, d);
    wait_tx(base + 14);
    wait_resp(rc + 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int nrep, input logic [31:0] rep,
                         input bit noise, input bit junk);
    int base, rc;
    logic [31:0] expd;
    base = tx_count;
    rc   = resp_count;
    expd = '0;
    for (int i = 0; i < nrep; i++) expd[8*i +: 8] = rep[8*i +: 8];
    push_frame(1'b0, a, 32'h0);
    exp_resp.push_back('{rd: 1'b1, data: expd, to: (nrep < 4)});
    issue(1'b0, a, 32'h0);
    if (noise) begin
      send_rx(8'h11, 1'b0);
      send_rx(8'h22, 1'b0);
    end
    wait_tx(base + 10);
    repeat (6) @(negedge clk);
    if (junk) begin
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (3 * B) @(negedge clk);
      send_rx(8'h99, 1'b1);
    end
    for (int i = 0; i < nrep; i++) send_rx(rep[8*i +: 8], 1'b0);
    wait_resp(rc + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc, ack_cyc, base, rc, ac, r1, t;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_resp", 32'(bus.resp_o), 32'd0);
    check("rst_timeout", 32'(bus.timeout_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write with exact latency from start bit to resp
    base = tx_count;
    rc   = resp_count;
    push_frame(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    exp_resp.push_back('{rd: 1'b0, data: 32'h0, to: 1'b0});
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    ack_cyc = cyc;
    check("busy_at_ack", 32'(bus.busy_o), 32'd1);
    check("tx_idle_at_ack", 32'(tx), 32'd1);
    @(negedge clk);
    check("start_bit", 32'(tx), 32'd0);
    start_cyc = ack_cyc + 1;
    wait_tx(base + 14);
    wait_resp(rc + 1);
    check("write_latency", 32'(last_resp_cyc - start_cyc), 32'(140 * B + 1));
    @(negedge clk);
    check("busy_after_resp", 32'(bus.busy_o), 32'd0);

    do_read(32'h8000_0000, 4, 32'h1234_5678, 1'b0, 1'b0);
    do_read(32'h0000_0ABF, 2, 32'h0000_BBAA, 1'b0, 1'b0);
    do_read(32'h4000_0020, 4, 32'hCAFE_F00D, 1'b1, 1'b1);

    // Reset during the 5th frame byte
    base = tx_count;
    push_frame(1'b1, 32'hFFFF_FFFF, 32'h0);
    exp_resp.push_back('{rd: 1'b0, data: 32'h0, to: 1'b0});
    issue(1'b1, 32'hFFFF_FFFF, 32'h0);
    wait_tx(base + 4);
    repeat (2 * B) @(negedge clk);
    tx_ignore = 1'b1;
    check("busy_before_rst", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    check("rst_mid_rdata", bus.rdata_o, 32'd0);
    rst = 1'b0;
    void'(exp_resp.pop_back());
    repeat (15 * B) @(negedge clk);
    exp_tx.delete();
    tx_ignore = 1'b0;
    do_write(32'h0000_2000, 32'h0123_4567);

    // Back-to-back requests with req held high
    rc = resp_count;
    ac = ack_count;
    push_frame(1'b1, 32'h0000_0100, 32'hA5A5_5A5A);
    push_frame(1'b0, 32'h0000_0200, 32'h0);
    exp_resp.push_back('{rd: 1'b0, data: 32'h0, to: 1'b0});
    exp_resp.push_back('{rd: 1'b1, data: 32'h0, to: 1'b1});
    @(negedge clk);
    bus.we_i = 1'b1; bus.addr_i = 32'h0000_0100; bus.wdata_i = 32'hA5A5_5A5A;
    bus.req_i = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ack_o && t < 100);
    bus.we_i = 1'b0; bus.addr_i = 32'h0000_0200; bus.wdata_i = 32'h0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.resp_o && t < 2000);
    r1 = cyc;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ack_o && t < 100);
    check("b2b_ack_gap", 32'(cyc - r1), 32'd1);
    bus.req_i = 1'b0;
    wait_resp(rc + 2);
    @(negedge clk);
    check("b2b_ack_count", 32'(ack_count - ac), 32'd2);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a, d;
      int nrep;
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d);
      end else begin
        nrep = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 4;
        do_read(a, nrep, d, 1'b0, 1'b0);
      end
    end

    repeat (20) @(negedge clk);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
